// File: rtl/tb_mmio_ctrl.sv
// tb_mmio_ctrl - testbench control peripheral for the core data-bus MMIO window.
//
// Serves every access in the window with a req/gnt/rvalid protocol:
//   EXIT     (word 0x00) write: capture exit code (first write wins)
//                        read : cycle[31:0], snapshots cycle[63:32] into shadow
//   PRINT    (word 0x01) write with be_i[0]: push wdata_i[7:0] to console FIFO
//   CYCLE_HI (word 0x02) read : shadow of cycle[63:32]
//   STATUS   (word 0x03) read : {16'b0, fifo_count, 6'b0, timeout, exit_valid}
//   WDOG     (word 0x04) watchdog limit (only with TB_MMIO_WATCHDOG_EN)
//
// Optional feature macro: TB_MMIO_WATCHDOG_EN (watchdog counter / timeout).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i, gnt_o         request (pre-decoded), combinational grant
//   addr_i, we_i, be_i,  byte address (only [7:2] decoded), write enable,
//   wdata_i              byte enables, write data
//   rvalid_o, rdata_o    response one cycle after grant
//   char_valid_o,        console FIFO head valid / head byte,
//   char_data_o,         popped when char_ready_i is high
//   char_ready_i
//   exit_valid_o,        sticky exit capture and its code
//   exit_code_o
//   timeout_o            sticky watchdog expiry
module tb_mmio_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        exit_valid_o,
    output logic [31:0] exit_code_o,
    output logic        timeout_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [5:0] {
        REG_EXIT     = 6'h00,
        REG_PRINT    = 6'h01,
        REG_CYCLE_HI = 6'h02,
        REG_STATUS   = 6'h03,
        REG_WDOG     = 6'h04
    } reg_e;

    logic [5:0]    off;
    logic          granted;
    logic          is_print_wr;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          exit_wr;
    logic          wd_fire;
    logic [31:0]   rdata_d;

    logic [63:0]   cycle_q;
    logic [31:0]   shadow_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          exit_valid_q;
    logic [31:0]   exit_code_q;

    logic          unused_ok;
    assign unused_ok = ^{addr_i[31:8], addr_i[1:0], be_i[3:1]};

    assign off         = addr_i[7:2];
    assign is_print_wr = we_i && (off == REG_PRINT);
    // Full uses the registered count, so a pop in this cycle cannot unblock it.
    assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign gnt_o       = req_i && !(is_print_wr && fifo_full);
    assign granted     = req_i && gnt_o;
    assign push        = granted && is_print_wr && be_i[0];
    assign pop         = (count_q != '0) && char_ready_i;
    assign exit_wr     = granted && we_i && (off == REG_EXIT);

`ifdef TB_MMIO_WATCHDOG_EN
    logic [31:0] wd_limit_q;
    logic [31:0] wd_cnt_q;
    logic        timeout_q;

    assign wd_fire = (wd_limit_q != '0) && !timeout_q && (wd_cnt_q == wd_limit_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_limit_q <= '0;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (granted) begin
                wd_cnt_q <= '0;
                if (we_i && (off == REG_WDOG)) begin
                    wd_limit_q <= wdata_i;
                end
            end else if ((wd_limit_q != '0) && !timeout_q) begin
                wd_cnt_q <= wd_cnt_q + 32'd1;
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Read mux; writes and ungranted cycles answer 0.
    always_comb begin
        rdata_d = '0;
        if (granted && !we_i) begin
            case (off)
                REG_EXIT:     rdata_d = cycle_q[31:0];
                REG_CYCLE_HI: rdata_d = shadow_q;
                REG_STATUS:   rdata_d = {16'b0, 8'(count_q), 6'b0, timeout_o, exit_valid_q};
`ifdef TB_MMIO_WATCHDOG_EN
                REG_WDOG:     rdata_d = wd_limit_q;
`endif
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q  <= '0;
            shadow_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cycle_q  <= cycle_q + 64'd1;
            rvalid_q <= granted;
            rdata_q  <= rdata_d;
            if (granted && !we_i && (off == REG_EXIT)) begin
                shadow_q <= cycle_q[63:32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else if (!exit_valid_q) begin
            if (exit_wr) begin
                exit_valid_q <= 1'b1;
                exit_code_q  <= wdata_i;
            end else if (wd_fire) begin
                exit_valid_q <= 1'b1;
                exit_code_q  <= TIMEOUT_CODE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign char_valid_o = (count_q != '0);
    // Storage is not reset; gate the head so an empty FIFO presents 0.
    assign char_data_o  = char_valid_o ? mem_q[rd_ptr_q] : '0;
    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;

endmodule

// File: tb/tb_tb_mmio_ctrl.sv
// Self-checking bench for tb_mmio_ctrl: directed scenarios plus randomized
// traffic, checked against a transaction-level model (cycle count, byte queue,
// exit/watchdog state). Build with TB_MMIO_WATCHDOG_EN to cover the watchdog.
module tb_tb_mmio_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] TCODE = 32'hDEAD_0001;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        char_valid_o;
    logic [7:0]  char_data_o;
    logic        char_ready_i;
    logic        exit_valid_o;
    logic [31:0] exit_code_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    tb_mmio_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CODE(TCODE)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .char_valid_o(char_valid_o),
        .char_data_o (char_data_o),
        .char_ready_i(char_ready_i),
        .exit_valid_o(exit_valid_o),
        .exit_code_o (exit_code_o),
        .timeout_o   (timeout_o)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic [63:0] m_cyc;
    logic [31:0] m_shadow;
    byte unsigned m_q[$];
    logic        m_exit_v;
    logic [31:0] m_exit_code;
    logic        m_tmo;
    logic [31:0] m_limit;
    logic [31:0] m_wd;
    int unsigned ready_mode;   // 0: low, 1: high, 2: random
    logic [63:0] pre_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc       = '0;
        m_shadow    = '0;
        m_q.delete();
        m_exit_v    = 1'b0;
        m_exit_code = '0;
        m_tmo       = 1'b0;
        m_limit     = '0;
        m_wd        = '0;
    endtask

    // One clock cycle: called in the low phase, returns at the next negedge.
    task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        logic [5:0]  off;
        logic        rdy, exp_gnt, pop, fire;
        logic [31:0] exp_rd;
        logic [7:0]  head;
        off = addr[7:2];
        rdy = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
        char_ready_i = rdy;
        #1;
        exp_gnt = req && !(off == 6'd1 && we && m_q.size() >= DEPTH);
        check("gnt", gnt_o, exp_gnt);
        exp_rd = '0;
        if (exp_gnt && !we) begin
            case (off)
                6'd0: exp_rd = m_cyc[31:0];
                6'd2: exp_rd = m_shadow;
                6'd3: exp_rd = {16'h0, 8'(m_q.size()), 6'b0, m_tmo, m_exit_v};
`ifdef TB_MMIO_WATCHDOG_EN
                6'd4: exp_rd = m_limit;
`endif
                default: exp_rd = '0;
            endcase
        end
        pop = rdy && (m_q.size() != 0);
`ifdef TB_MMIO_WATCHDOG_EN
        fire = (m_limit != 0) && !m_tmo && (m_wd == m_limit);
`else
        fire = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("rvalid", rvalid_o, exp_gnt);
        check("rdata", rdata_o, exp_rd);
        if (exp_gnt && !we && off == 6'd0) m_shadow = m_cyc[63:32];
        m_cyc = m_cyc + 64'd1;
        if (pop) void'(m_q.pop_front());
        if (exp_gnt && we && off == 6'd1 && be[0]) m_q.push_back(wdata[7:0]);
        if (!m_exit_v) begin
            if (exp_gnt && we && off == 6'd0) begin
                m_exit_v = 1'b1; m_exit_code = wdata;
            end else if (fire) begin
                m_exit_v = 1'b1; m_exit_code = TCODE;
            end
        end
`ifdef TB_MMIO_WATCHDOG_EN
        if (exp_gnt) begin
            m_wd = '0;
            if (we && off == 6'd4) m_limit = wdata;
        end else if (m_limit != 0 && !m_tmo) begin
            m_wd = m_wd + 1;
        end
        if (fire) m_tmo = 1'b1;
`endif
        head = (m_q.size() != 0) ? m_q[0] : 8'h00;
        check("char_valid", char_valid_o, m_q.size() != 0);
        check("char_data", char_data_o, head);
        check("exit_valid", exit_valid_o, m_exit_v);
        check("exit_code", exit_code_o, m_exit_code);
        check("timeout", timeout_o, m_tmo);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr);
        cycle(1'b1, 1'b0, addr, 4'hF, $urandom);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
        cycle(1'b1, 1'b1, addr, be, d);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        char_ready_i = 1'b0;
        #2;
        check("rst_gnt", gnt_o, 1'b0);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_char_valid", char_valid_o, 1'b0);
        check("rst_char_data", char_data_o, 8'h0);
        check("rst_exit_valid", exit_valid_o, 1'b0);
        check("rst_exit_code", exit_code_o, 32'h0);
        check("rst_timeout", timeout_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic preload(input logic [63:0] v);
        pre_val = v;
        force dut.cycle_q = pre_val;
        #1;
        release dut.cycle_q;
        m_cyc = v;
    endtask

    initial begin
        logic [31:0] a;
        ready_mode = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle then EXIT read returns the cycle count
        idle(10);
        rd(32'h00);

        // Hi/lo coherence across a 32-bit carry and a full 64-bit wrap
        preload(64'h0000_0000_FFFF_FFFA);
        for (int i = 0; i < 6; i++) begin rd(32'h00); rd(32'h08); end
        preload(64'hFFFF_FFFF_FFFF_FFFB);
        for (int i = 0; i < 6; i++) begin rd(32'h00); rd(32'h08); end

        // Console ordering
        wr(32'h04, 4'h1, 32'h48);
        wr(32'h04, 4'h1, 32'h69);
        wr(32'h04, 4'h1, 32'h0A);
        wr(32'h04, 4'h0, 32'h55);          // be_i[0]=0: completes, no push
        rd(32'h0C);
        ready_mode = 1;
        idle(5);
        rd(32'h0C);

        // FIFO full backpressure
        ready_mode = 0;
        for (int i = 0; i < DEPTH; i++) wr(32'h04, 4'h1, 32'(8'h30 + i));
        for (int i = 0; i < 3; i++) wr(32'h04, 4'h1, 32'h7A);
        rd(32'h0C);
        rd(32'h08);
        wr(32'h14, 4'hF, 32'h1234);
        ready_mode = 1;
        wr(32'h04, 4'h1, 32'h7A);          // pop this cycle still blocks
        ready_mode = 0;
        wr(32'h04, 4'h1, 32'h7A);          // now granted
        rd(32'h0C);
        ready_mode = 1;
        idle(DEPTH + 2);

        // Exit first-write-wins
        wr(32'h00, 4'h0, 32'h0);
        wr(32'h00, 4'hF, 32'h5);
        rd(32'h0C);

        // Mid-operation reset drops FIFO content and the pending request
        ready_mode = 0;
        wr(32'h04, 4'h1, 32'hAB);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0C;
        #2;
        do_reset();
        check("post_rst_rvalid", rvalid_o, 1'b0);
        idle(2);

        // Randomized traffic
        ready_mode = 2;
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] d;
            a = $urandom;
            a[7:2] = 6'($urandom_range(0, 7));
            d = $urandom;
            if (a[7:2] == 6'd4) d = $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0)
                cycle(1'b1, 1'b1, a, 4'($urandom), d);
            else
                cycle($urandom_range(0, 3) != 0, 1'b0, a, 4'($urandom), d);
        end

`ifdef TB_MMIO_WATCHDOG_EN
        // Watchdog expiry with no accesses
        ready_mode = 0;
        do_reset();
        wr(32'h10, 4'hF, 32'd100);
        idle(130);
        check("wd_timeout", timeout_o, 1'b1);
        check("wd_code", exit_code_o, TCODE);
        // Periodic accesses keep it from firing
        do_reset();
        wr(32'h10, 4'hF, 32'd100);
        for (int i = 0; i < 6; i++) begin idle(49); rd(32'h10); end
        check("wd_no_timeout", timeout_o, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tb_mmio_ctrl.md
# tb_mmio_ctrl

Memory-mapped testbench control peripheral on the core data bus, downstream of the bench's data-address decoder. It serves every access in the MMIO window: exit-code capture, a buffered character console, a 64-bit cycle counter with coherent snapshot reads, and a status register. It replaces ad-hoc MMIO decode in the bench top, with a bus-correct req/gnt/rvalid protocol and console backpressure.

## Interface
- FIFO_DEPTH, 16: console character FIFO entries; power of two, ≥2.
- TIMEOUT_CODE, 32'hDEAD_0001: exit code forced by the watchdog.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  pre-decoded request (address already in MMIO window).
- gnt_o  out  1  grant, combinational.
- addr_i  in  32  byte address; only addr_i[7:2] decoded.
- we_i  in  1  1 = write.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data, valid with rvalid_o.
- char_valid_o  out  1  console FIFO head valid.
- char_data_o  out  8  console FIFO head byte.
- char_ready_i  in  1  consumer pops the head when high with char_valid_o.
- exit_valid_o  out  1  exit code captured (sticky).
- exit_code_o  out  32  captured exit code.
- timeout_o  out  1  watchdog fired (sticky).

## Operation
- Register map (word offsets addr_i[7:2]):
  - 0x00 EXIT: write captures wdata_i as exit code, be_i ignored. Read returns cycle[31:0] and snapshots cycle[63:32] into a shadow register.
  - 0x04 PRINT: write with be_i[0]=1 pushes wdata_i[7:0] into the FIFO; be_i[0]=0 is ignored but completes. Read returns 0.
  - 0x08 CYCLE_HI: read returns the shadow register. Writes ignored.
  - 0x0C STATUS: read {16'b0, fifo_count[7:0], 6'b0, timeout, exit_valid}. Writes ignored.
  - 0x10 WDOG: write loads watchdog limit (0 = disabled) and clears the watchdog counter. Read returns the limit.
  - Any other offset: read 0, write ignored, still granted and answered.
- Exit is first-write-wins: once exit_valid_o=1, later EXIT writes and watchdog expiry leave exit_code_o unchanged.
- Cycle counter: 64 bits, 0 at reset, +1 every cycle, wraps at 2^64-1 to 0.
- FIFO: circular, FIFO_DEPTH entries, log2(FIFO_DEPTH)+1-bit count. Push and pop in the same cycle leave the count unchanged; data stays in order.
- Reset values: gnt_o follows comb rule, rvalid_o=0, rdata_o=0, char_valid_o=0, char_data_o=0, exit_valid_o=0, exit_code_o=0, timeout_o=0. FIFO empty, counter 0, shadow 0, limit 0.
- Reset mid-operation drops pending FIFO content and any in-flight response. No rvalid_o follows reset.

## Timing
- gnt_o = req_i, except PRINT writes: gnt_o = req_i & ~full, using the registered count. A pop in the same cycle does not unblock a full FIFO.
- Granted transaction (req_i & gnt_o) → rvalid_o=1 exactly one cycle later, for reads and writes. rdata_o=0 for writes. At most one response per cycle, with back-to-back grants every cycle.
- Register effects (exit capture, push, limit load) are visible in outputs the cycle after grant. A STATUS read granted in the same cycle as a PRINT push returns the pre-push count.
- EXIT read: rdata_o = counter value sampled in the grant cycle. The shadow updates in that same edge, so a CYCLE_HI read granted in the next cycle is coherent.
- char_valid_o = count≠0. char_data_o = head entry, registered, no fall-through. A byte pushed at edge N is visible at edge N.

## Configuration
- TB_MMIO_WATCHDOG_EN defined: the watchdog counter increments each cycle while limit≠0 and timeout_o=0. When it equals limit:
  - timeout_o=1 next cycle.
  - If no exit has been captured, exit_valid_o=1 and exit_code_o=TIMEOUT_CODE.
  - Any granted access (any offset) resets the counter to 0.
- Not defined: no watchdog logic. WDOG offset behaves as unmapped (read 0). timeout_o is tied 0; STATUS bit1 reads 0.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values. Then read 0x00 → rvalid_o one cycle after grant, rdata_o = 10 ±0 vs bench counter model.
- Force cycle[31:0]=32'hFFFF_FFFF region (run to wrap via hierarchical preload), then read 0x00, then 0x08 → hi/lo pair consistent, hi not incremented between reads.
- Write 'H','i','\n' to 0x04 with char_ready_i=0 → STATUS count=3. Then ready=1 → bytes 0x48, 0x69, 0x0A out in order, char_valid_o drops after third pop.
- Fill FIFO with 16 pushes, ready=0 → 17th PRINT write sees gnt_o=0 until one pop, then is granted next cycle. Other offsets still granted while full.
- Write 0 then 5 to 0x00 → exit_valid_o=1, exit_code_o=0, unchanged after second write. Both writes get rvalid_o.
- With TB_MMIO_WATCHDOG_EN: write 100 to 0x10, no further accesses → timeout_o=1 after 100 cycles, exit_code_o=32'hDEAD_0001. Same run with an access every 50 cycles → no timeout.
